// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the core (port 0) and the host loader (port 1).
// Define DM_ARB_RR_EN for round-robin tie-break; otherwise the host wins ties.
module dm_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic last_owner, forced;
    logic acc0, acc1, acc, own_req, oth_req, limit, force_go, tie_pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A forced handover leaves a one-cycle IDLE; forced makes the waiting port win the tie there
    always_comb begin
        acc0       = (state == OWN0) && req0;
        acc1       = (state == OWN1) && req1;
        acc        = acc0 || acc1;
        own_req    = (state == OWN1) ? req1 : req0;
        oth_req    = (state == OWN1) ? req0 : req1;
        limit      = (cnt == MAXC) || (acc && cnt == MAXC - 1'b1);
        force_go   = (state != IDLE) && own_req && oth_req && limit;
        tie_pick   = (RR || forced) ? ~last_owner : 1'b1;
        next_state = (state == IDLE) ? ((req0 && req1) ? (tie_pick ? OWN1 : OWN0) :
                                        req1 ? OWN1 : req0 ? OWN0 : IDLE) :
                     !own_req ? (oth_req ? ((state == OWN0) ? OWN1 : OWN0) : IDLE) :
                     force_go ? IDLE : state;
    end

    always_comb begin
        gnt0      = (state == OWN0);
        gnt1      = (state == OWN1);
        mem_wr    = acc0 ? we0 : acc1 ? we1 : 1'b0;
        mem_addr  = acc0 ? addr0 : acc1 ? addr1 : '0;
        mem_wdata = acc0 ? wdata0 : acc1 ? wdata1 : '0;
        rdata     = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            last_owner <= 1'b1;
            forced     <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            cnt        <= (next_state != state) ? '0 : (acc && cnt != MAXC) ? cnt + 1'b1 : cnt;
            last_owner <= (state == OWN0) ? 1'b0 : (state == OWN1) ? 1'b1 : last_owner;
            forced     <= (state == IDLE) ? forced : force_go;
            rvalid0    <= acc0 && !we0;
            rvalid1    <= acc1 && !we1;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with MAX_BURST=4 and a synchronous memory model.
module tb_dm_arbiter;
    localparam int AW = 16, DW = 8, MB = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0, mem_addr;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata, mem_wdata, mem_rdata = '0;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_wr;
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] q0[$], q1[$];
    logic [AW+DW-1:0] qw[$];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (rst) mem[16'h0010] <= 8'h5A;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    task automatic gchk(input string n, input logic e0, input logic e1);
        @(negedge clk);
        chk({n, "_gnt0"}, gnt0, e0);
        chk({n, "_gnt1"}, gnt1, e1);
    endtask

    // Monitor: pops expected writes and read data whenever the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr) begin
                if (qw.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexp_write: got %h/%h expected no write", mem_addr, mem_wdata);
                end else chk("write", {mem_addr, mem_wdata}, qw.pop_front());
            end
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexp_rvalid0: got rdata %h expected no rvalid0", rdata);
                end else chk("rdata0", rdata, q0.pop_front());
            end
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexp_rvalid1: got rdata %h expected no rvalid1", rdata);
                end else chk("rdata1", rdata, q1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_mem_wr", mem_wr, 0);
        nx; rst = 0;
        nx;
        // single core read
        nx; req0 = 1; we0 = 0; addr0 = 16'h0010; q0.push_back(8'h5A);
        gchk("t1_req", 0, 0);
        nx;
        gchk("t1_acc", 1, 0);
        chk("t1_addr", mem_addr, 16'h0010);
        chk("t1_wr", mem_wr, 0);
        nx; req0 = 0;
        nx; nx;
        // host write burst then readback
        nx; req1 = 1; we1 = 1; addr1 = 16'h0100; wdata1 = 8'h01;
        for (int k = 0; k < 4; k++) qw.push_back({16'h0100 + 16'(k), 8'(k + 1)});
        for (int k = 0; k < 4; k++) begin
            nx; addr1 = 16'h0100 + 16'(k); wdata1 = 8'(k + 1);
            gchk("t2_burst", 0, 1);
        end
        nx; req1 = 0; we1 = 0;
        nx;
        nx; req1 = 1; addr1 = 16'h0102; q1.push_back(8'h03);
        nx;
        gchk("t2_rb", 0, 1);
        nx; req1 = 0;
        nx; nx;
        // simultaneous requests from IDLE, twice
        for (int r = 0; r < 2; r++) begin
`ifdef DM_ARB_RR_EN
            w = (r == 1);
`else
            w = 1'b1;
`endif
            nx; req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0010; addr1 = 16'h0102;
            if (w) q1.push_back(8'h03); else q0.push_back(8'h5A);
            nx;
            gchk("t3_tie", !w, w);
            nx; req0 = 0; req1 = 0;
            nx; nx;
        end
        // starvation bound in both directions
        for (int k = 0; k < 4; k++) qw.push_back({16'h0200 + 16'(k), 8'hA0 + 8'(k)});
        for (int k = 0; k < 4; k++) qw.push_back({16'h0300 + 16'(k), 8'hB0 + 8'(k)});
        qw.push_back({16'h0204, 8'hA4});
        nx; req0 = 1; we0 = 1; addr0 = 16'h0200; wdata0 = 8'hA0; we1 = 1; addr1 = 16'h0300; wdata1 = 8'hB0;
        for (int c = 1; c <= 11; c++) begin
            nx;
            if (c <= 4) begin addr0 = 16'h0200 + 16'(c - 1); wdata0 = 8'hA0 + 8'(c - 1); end
            else if (c == 11) begin addr0 = 16'h0204; wdata0 = 8'hA4; end
            req1 = (c >= 2 && c <= 10);
            if (c >= 6 && c <= 9) begin addr1 = 16'h0300 + 16'(c - 6); wdata1 = 8'hB0 + 8'(c - 6); end
            gchk($sformatf("t4_c%0d", c), (c <= 4 || c == 11), (c >= 6 && c <= 9));
        end
        nx; req0 = 0; we0 = 0; we1 = 0;
        nx; nx;
        // direct handover with a read in port 0's last access
        nx; req0 = 1; we0 = 0; addr0 = 16'h0010; q0.push_back(8'h5A);
        nx; req1 = 1; we1 = 0; addr1 = 16'h0102; q1.push_back(8'h03);
        gchk("t5_own0", 1, 0);
        nx; req0 = 0;
        gchk("t5_drop", 1, 0);
        nx;
        gchk("t5_hand", 0, 1);
        nx; req1 = 0;
        nx; nx;
        // reset during a read
        nx; req0 = 1; we0 = 0; addr0 = 16'h0010;
        nx;
        gchk("t6_acc", 1, 0);
        nx; rst = 1; req0 = 0;
        #1;
        chk("t6_rvalid0", rvalid0, 0);
        chk("t6_gnt0", gnt0, 0);
        chk("t6_mem_wr", mem_wr, 0);
        nx; rst = 0;
        gchk("t6_idle", 0, 0);
        nx; req0 = 1; q0.push_back(8'h5A);
        gchk("t6_req", 0, 0);
        nx;
        gchk("t6_regrant", 1, 0);
        nx; req0 = 0;
        nx; nx; nx;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("qw_empty", qw.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single data-memory port between the matrix-multiply core and a host loader, the UART/DMA path that preloads operand matrices and reads back results. It sits between the requesters and the data memory. It grants one owner at a time, forwards the owner's address, write strobe and data to memory, and returns read-valid tags. A burst counter bounds how long one owner can hold the port, so neither side starves.

## Interface
- ADDR_WIDTH, 16, data-memory address width
- DATA_WIDTH, 8, data-memory word width
- MAX_BURST, 16, maximum consecutive accesses per grant when the other port is waiting (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, core (0) / host (1); held high for the whole burst
- we0 / we1  in  1  write strobe for the current access
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  registered grant; at most one high
- rvalid0 / rvalid1  out  1  registered; rdata holds this port's read result
- rdata  out  DATA_WIDTH  shared read data, a combinational pass-through of mem_rdata
- mem_addr  out  ADDR_WIDTH  to memory
- mem_wr  out  1  to memory write enable
- mem_wdata  out  DATA_WIDTH  to memory
- mem_rdata  in  DATA_WIDTH  from memory; synchronous read, valid one cycle after the address

## Operation
- State machine has three states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1).
- An access occurs in any cycle where gntN & reqN. In that cycle:
  - mem_addr = addrN, mem_wdata = wdataN, mem_wr = weN.
  - Otherwise mem_wr=0, mem_addr=0, mem_wdata=0.
- A read access (weN=0) sets rvalidN=1 on the next cycle. Write accesses never raise rvalid.
- IDLE transitions:
  - Only one request high: go to that port's OWN state.
  - Both high: arbitration picks the owner.
- OWNn transitions:
  - reqN low: hand over. Go to OWN of the other port if its req is high, else IDLE. There is no idle bubble when the other port is waiting.
  - Forced handover: the burst counter reaches MAX_BURST and the other req is high. Go to IDLE for one cycle, then the other port wins arbitration.
- Burst counter:
  - Counts accesses in the current OWN state.
  - Clears on every state change.
  - Saturates at MAX_BURST when the other port is not requesting; the owner keeps the port.
- last_owner register records the most recent granted port.

## Timing
- Request-to-grant latency: req rises in cycle t, gnt is high in t+1, and the first access happens in t+1.
- Read latency: access in cycle t, rvalidN and valid rdata in t+1.
- Back-to-back accesses: one per cycle while req and gnt stay high.
- Reset values: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, counter=0, last_owner=1 (so the core wins the first tie), mem_wr=0.
- Reset mid-operation: all outputs clear immediately. An in-flight read's rvalid is dropped, and the requester must reissue.
- Handover and reads: a read issued in an owner's final granted cycle still returns rvalid to that owner on the next cycle, even though gnt has already moved.
- req and gnt: a requester drops req only after its last access cycle. req low with gnt high produces no access.

## Configuration
- DM_ARB_RR_EN defined: round-robin tie-break. When both requests are high in IDLE, grant the port that is not last_owner.
- Without it: fixed priority, host (port 1) always wins ties. MAX_BURST forced handover still applies, so the core cannot starve indefinitely.

## Test plan
- Single core read: after reset, req0=1, we0=0, addr0=0x0010, and memory holds 0x5A. Expect gnt0 high the next cycle, mem_addr=0x0010, mem_wr=0, then rvalid0=1 with rdata=0x5A one cycle later.
- Host write burst: req1 held for 4 cycles, we1=1, addr 0x0100..0x0103, data 0x01..0x04. Expect 4 consecutive mem_wr pulses with matching addr/data and rvalid1 never asserted.
- Simultaneous requests from IDLE: req0 and req1 rise together. With DM_ARB_RR_EN: port 0 is granted first (reset last_owner=1); on repeat, port 1 is granted. Without it: port 1 is granted both times.
- Starvation bound: MAX_BURST=4, port 0 holds req continuously, port 1 requests at cycle 2. Expect gnt0 for exactly 4 accesses, one IDLE cycle, then gnt1.
- Direct handover: port 0 drops req while port 1 is waiting. Expect gnt1 in the next cycle with no IDLE gap. A read in port 0's last access still yields rvalid0.
- Reset during read: assert rst in the cycle after a port-0 read access. Expect rvalid0, gnt0 and mem_wr all at 0 immediately, and state IDLE after rst deasserts.
